// File: rtl/readout_frame_pkg.sv
// Shared constants and encodings for the readout frame serializer.
package readout_frame_pkg;

   localparam logic [31:0] HEADER_DEF = 32'h00AA_AAAA;
   localparam logic [31:0] FOOTER_DEF = 32'h00FF_FFFF;
   localparam logic [7:0]  CRC8_POLY  = 8'h07;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_CAPT,
      ST_SEND,
      ST_CRC
   } state_e;

   typedef enum logic [1:0] {
      PH_HUNT,
      PH_DATA,
      PH_FOOT
   } phase_e;

   // CRC-8, MSB-first, one byte per call.
   function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/readout_frame_serializer_word2byte_ser.sv
// word2byte_ser: loads a 32-bit word and emits it MSB byte first on a valid/ready
// handshake, pulsing done_o as the fourth byte is accepted.
module word2byte_ser
   import readout_frame_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic [31:0] word_i,
   input  logic        ready_i,
   output logic [7:0]  byte_o,
   output logic        valid_o,
   output logic        done_o
);

   logic [31:0] word_q, word_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        valid_q, valid_d;
   logic        fire;

   assign fire = valid_q & ready_i;

   always_comb begin
      // NOTE: every always_comb target is defaulted first so no path can infer a latch.
      word_d  = word_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      if (load_i) begin
         word_d  = word_i;
         cnt_d   = 2'd0;
         valid_d = 1'b1;
      end else if (fire) begin
         // Shifting in zeros leaves byte_o at 0 once the word is drained.
         word_d = {word_q[23:0], 8'h00};
         cnt_d  = cnt_q + 2'd1;
         if (cnt_q == 2'd3) begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      if (rst_i) begin
         word_q  <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         word_q  <= word_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   assign byte_o  = word_q[31:24];
   assign valid_o = valid_q;
   assign done_o  = fire & (cnt_q == 2'd3);

endmodule

// File: rtl/readout_frame_serializer.sv
// Pops framed words from the readout FIFO, checks HEADER/DATA/FOOTER structure and
// streams accepted words as bytes. Define READOUT_CRC_EN to append a CRC-8 per frame.
module readout_frame_serializer
   import readout_frame_pkg::*;
#(
   parameter int          DATA_WORDS = 256,
   parameter logic [31:0] HEADER     = HEADER_DEF,
   parameter logic [31:0] FOOTER     = FOOTER_DEF,
   parameter int          CNT_W      = 16
)(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             fifo_empty_i,
   input  logic [31:0]      fifo_data_i,
   output logic             fifo_rd_o,
   output logic [7:0]       byte_o,
   output logic             byte_valid_o,
   input  logic             byte_ready_i,
   output logic [CNT_W-1:0] frame_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic             busy_o
);

   localparam int               IDX_W    = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WORDS - 1);

   state_e           state_q, state_d;
   phase_e           phase_q, phase_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic             load, accept_hdr, err_inc, frame_inc;
   logic [7:0]       ser_byte;
   logic             ser_valid, ser_done;
`ifdef READOUT_CRC_EN
   logic [7:0]       crc_q, crc_d;
   logic             footer_q, footer_d;
`endif

   word2byte_ser u_ser (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (load),
      .word_i  (fifo_data_i),
      .ready_i (byte_ready_i),
      .byte_o  (ser_byte),
      .valid_o (ser_valid),
      .done_o  (ser_done)
   );

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      idx_d      = idx_q;
      load       = 1'b0;
      accept_hdr = 1'b0;
      err_inc    = 1'b0;
      frame_inc  = 1'b0;
`ifdef READOUT_CRC_EN
      crc_d      = crc_q;
      footer_d   = footer_q;
`endif
      case (state_q)
         ST_IDLE: if (!fifo_empty_i) state_d = ST_RD;
         ST_RD:   state_d = ST_CAPT;
         ST_CAPT: begin
            state_d = ST_IDLE;
            case (phase_q)
               PH_HUNT: begin
                  if (fifo_data_i == HEADER) accept_hdr = 1'b1;
                  else                       err_inc    = 1'b1;
               end
               PH_DATA: begin
                  load = 1'b1;
                  if (idx_q == IDX_LAST) phase_d = PH_FOOT;
                  else                   idx_d   = idx_q + IDX_W'(1);
               end
               PH_FOOT: begin
                  if (fifo_data_i == FOOTER) begin
                     load      = 1'b1;
                     frame_inc = 1'b1;
                     phase_d   = PH_HUNT;
                  end else if (fifo_data_i == HEADER) begin
                     // Missing footer: count it, but resync on the new header.
                     err_inc    = 1'b1;
                     accept_hdr = 1'b1;
                  end else begin
                     err_inc = 1'b1;
                     phase_d = PH_HUNT;
                  end
               end
               default: phase_d = PH_HUNT;
            endcase
            if (accept_hdr) begin
               load    = 1'b1;
               phase_d = PH_DATA;
               idx_d   = '0;
`ifdef READOUT_CRC_EN
               crc_d   = 8'h00;
`endif
            end
`ifdef READOUT_CRC_EN
            footer_d = (phase_q == PH_FOOT) && (fifo_data_i == FOOTER);
`endif
            if (load) state_d = ST_SEND;
         end
         ST_SEND: begin
`ifdef READOUT_CRC_EN
            if (ser_valid && byte_ready_i) crc_d = crc8_update(crc_q, ser_byte);
            if (ser_done) state_d = footer_q ? ST_CRC : ST_IDLE;
`else
            if (ser_done) state_d = ST_IDLE;
`endif
         end
         ST_CRC:  if (byte_ready_i) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      frame_cnt_d = (frame_inc && (frame_cnt_q != '1)) ? frame_cnt_q + CNT_W'(1) : frame_cnt_q;
      err_cnt_d   = (err_inc   && (err_cnt_q   != '1)) ? err_cnt_q   + CNT_W'(1) : err_cnt_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         phase_q     <= PH_HUNT;
         idx_q       <= '0;
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
`ifdef READOUT_CRC_EN
         crc_q       <= 8'h00;
         footer_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         idx_q       <= idx_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
`ifdef READOUT_CRC_EN
         crc_q       <= crc_d;
         footer_q    <= footer_d;
`endif
      end
   end

`ifdef READOUT_CRC_EN
   assign byte_o       = (state_q == ST_CRC) ? crc_q : ser_byte;
   assign byte_valid_o = ser_valid | (state_q == ST_CRC);
`else
   assign byte_o       = ser_byte;
   assign byte_valid_o = ser_valid;
`endif
   assign fifo_rd_o   = (state_q == ST_RD);
   assign busy_o      = (state_q != ST_IDLE);
   assign frame_cnt_o = frame_cnt_q;
   assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_readout_frame_serializer.sv
// Directed bench for readout_frame_serializer: behavioural FIFO, byte sink and
// per-scenario tasks with hand-derived expectations.
module tb_readout_frame_serializer;

   localparam logic [31:0] HDR = 32'h00AA_AAAA;
   localparam logic [31:0] FTR = 32'h00FF_FFFF;
   localparam int          NW  = 256;
`ifdef READOUT_CRC_EN
   localparam int          FRAME_BYTES = 1033;
`else
   localparam int          FRAME_BYTES = 1032;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        fifo_empty_i = 1'b1;
   logic [31:0] fifo_data_i = 32'h0;
   logic        fifo_rd_o;
   logic [7:0]  byte_o;
   logic        byte_valid_o;
   logic        byte_ready_i = 1'b0;
   logic [15:0] frame_cnt_o;
   logic [15:0] err_cnt_o;
   logic        busy_o;

   int total = 0;
   int bad   = 0;

   logic [31:0] fifo_q[$];
   logic [7:0]  got_q[$];
   logic [7:0]  exp_q[$];
   logic [31:0] fifo_w;
   int          stall_viol = 0, rd_viol = 0, stall_cycles = 0, pop_empty = 0;
   logic        prev_stall = 1'b0, prev_rd = 1'b0;
   logic [7:0]  prev_byte = 8'h00;

   always #5 clk_i = ~clk_i;

   readout_frame_serializer dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .fifo_empty_i (fifo_empty_i),
      .fifo_data_i  (fifo_data_i),
      .fifo_rd_o    (fifo_rd_o),
      .byte_o       (byte_o),
      .byte_valid_o (byte_valid_o),
      .byte_ready_i (byte_ready_i),
      .frame_cnt_o  (frame_cnt_o),
      .err_cnt_o    (err_cnt_o),
      .busy_o       (busy_o)
   );

   // Standard FIFO: read data appears just after the edge that ends the read cycle.
   always @(negedge clk_i) begin
      if (fifo_rd_o && !rst_i) begin
         if (fifo_q.size() == 0) begin
            pop_empty++;
            fifo_w = 32'hDEAD_BEEF;
         end else begin
            fifo_w = fifo_q.pop_front();
         end
         fifo_empty_i = (fifo_q.size() == 0);
         fifo_data_i  = 32'hDEAD_BEEF;
         @(posedge clk_i);
         #1;
         fifo_data_i = fifo_w;
      end
   end

   // Byte sink and protocol watcher.
   always @(negedge clk_i) begin
      if (rst_i) begin
         prev_stall = 1'b0;
         prev_rd    = 1'b0;
      end else begin
         if (fifo_rd_o && (byte_valid_o || prev_rd)) rd_viol++;
         if (prev_stall) begin
            stall_cycles++;
            if (!byte_valid_o || byte_o !== prev_byte) stall_viol++;
         end
         if (byte_valid_o && byte_ready_i) got_q.push_back(byte_o);
         prev_stall = byte_valid_o && !byte_ready_i;
         prev_byte  = byte_o;
         prev_rd    = fifo_rd_o;
      end
   end

   task automatic push_word(input logic [31:0] w);
      fifo_q.push_back(w);
      fifo_empty_i = 1'b0;
   endtask

   task automatic exp_word(input logic [31:0] w);
      exp_q.push_back(w[31:24]);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
   endtask

   function automatic logic [7:0] model_crc(input int from, input int upto);
      logic [7:0] c = 8'h00;
      logic       fb;
      for (int i = from; i < upto; i++) begin
         for (int b = 7; b >= 0; b--) begin
            fb = c[7] ^ exp_q[i][b];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
         end
      end
      return c;
   endfunction

   task automatic push_clean_frame();
      push_word(HDR);
      for (int i = 0; i < NW; i++) push_word(32'(i));
      push_word(FTR);
   endtask

   task automatic exp_clean_frame();
      int start = exp_q.size();
      exp_word(HDR);
      for (int i = 0; i < NW; i++) exp_word(32'(i));
      exp_word(FTR);
`ifdef READOUT_CRC_EN
      exp_q.push_back(model_crc(start, exp_q.size()));
`endif
   endtask

   // Index of first differing byte over the common length, -1 when none.
   function automatic int first_diff();
      int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
      return -1;
   endfunction

   task automatic do_reset();
      rst_i        = 1'b1;
      byte_ready_i = 1'b0;
      fifo_q.delete();
      fifo_empty_i = 1'b1;
      repeat (2) @(negedge clk_i);
      got_q.delete();
      exp_q.delete();
      stall_viol = 0; rd_viol = 0; stall_cycles = 0; pop_empty = 0;
      rst_i = 1'b0;
      @(negedge clk_i);
   endtask

   // mode 0: always ready; mode 1: 10-cycle stall mid-word, then ready toggling.
   task automatic drain(input string name, input int mode);
      int cyc = 0, idle_run = 0, stall_left = 0;
      bit stalled = 0;
      while (idle_run < 4 && cyc < 20000) begin
         @(posedge clk_i);
         #1;
         cyc++;
         if (mode == 0) begin
            byte_ready_i = 1'b1;
         end else begin
            if (!stalled && got_q.size() >= 2) begin
               stalled    = 1;
               stall_left = 10;
            end
            if (stall_left > 0) begin
               byte_ready_i = 1'b0;
               stall_left--;
            end else if (stalled) begin
               byte_ready_i = cyc[0];
            end else begin
               byte_ready_i = 1'b1;
            end
         end
         idle_run = (fifo_q.size() == 0 && !busy_o) ? idle_run + 1 : 0;
      end
      total++;
      if (cyc >= 20000) begin
         bad++;
         $display("FAIL %s drain: still busy after %0d cycles, required idle", name, cyc);
      end
   endtask

   task automatic check_stream(input string name);
      int d;
      total++;
      if (got_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL %s byte count: got %0d, required %0d", name, got_q.size(), exp_q.size());
      end
      total++;
      d = first_diff();
      if (d != -1) begin
         bad++;
         $display("FAIL %s stream byte %0d: got %02h, required %02h", name, d, got_q[d], exp_q[d]);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) @(negedge clk_i);
      total++; if (byte_valid_o !== 1'b0) begin bad++; $display("FAIL reset valid: got %b, required 0", byte_valid_o); end
      total++; if (byte_o !== 8'h00)      begin bad++; $display("FAIL reset byte: got %h, required 00", byte_o); end
      total++; if (fifo_rd_o !== 1'b0)    begin bad++; $display("FAIL reset rd: got %b, required 0", fifo_rd_o); end
      total++; if (busy_o !== 1'b0)       begin bad++; $display("FAIL reset busy: got %b, required 0", busy_o); end
      total++; if (frame_cnt_o !== 16'd0) begin bad++; $display("FAIL reset frame_cnt: got %0d, required 0", frame_cnt_o); end
      total++; if (err_cnt_o !== 16'd0)   begin bad++; $display("FAIL reset err_cnt: got %0d, required 0", err_cnt_o); end
      rst_i = 1'b0;
      repeat (5) @(negedge clk_i);
      total++;
      if (busy_o !== 1'b0 || fifo_rd_o !== 1'b0) begin
         bad++;
         $display("FAIL idle_empty: busy=%b rd=%b, required 0 0", busy_o, fifo_rd_o);
      end
   endtask

   task automatic test_latency();
      int rd_at = -1, v_at = -1;
      do_reset();
      push_word(HDR);
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk_i);
         if (fifo_rd_o && rd_at < 0) rd_at = n;
         if (byte_valid_o && v_at < 0) v_at = n;
      end
      total++; if (rd_at != 1) begin bad++; $display("FAIL latency rd cycle: got %0d, required 1", rd_at); end
      total++; if (v_at != 3)  begin bad++; $display("FAIL latency valid cycle: got %0d, required 3", v_at); end
      total++; if (byte_o !== 8'h00) begin bad++; $display("FAIL latency first byte: got %h, required 00", byte_o); end
   endtask

   task automatic test_clean_frame();
      logic [63:0] first8 = '0;
      logic [31:0] last4  = '0;
      do_reset();
      push_clean_frame();
      exp_clean_frame();
      drain("clean", 0);
      total++;
      if (got_q.size() != FRAME_BYTES) begin
         bad++;
         $display("FAIL clean length: got %0d, required %0d", got_q.size(), FRAME_BYTES);
      end
      if (got_q.size() >= 1032) begin
         for (int i = 0; i < 8; i++) first8 = {first8[55:0], got_q[i]};
         for (int i = 1028; i < 1032; i++) last4 = {last4[23:0], got_q[i]};
      end
      total++; if (first8 !== 64'h00AA_AAAA_0000_0000) begin bad++; $display("FAIL clean head bytes: got %h, required 00aaaaaa00000000", first8); end
      total++; if (last4 !== 32'h00FF_FFFF) begin bad++; $display("FAIL clean footer bytes: got %h, required 00ffffff", last4); end
`ifdef READOUT_CRC_EN
      total++;
      if (got_q.size() < 1033 || got_q[1032] !== model_crc(0, 1032)) begin
         bad++;
         $display("FAIL clean crc: got %02h, required %02h", (got_q.size() > 1032) ? got_q[1032] : 8'hxx, model_crc(0, 1032));
      end
`endif
      total++; if (frame_cnt_o !== 16'd1) begin bad++; $display("FAIL clean frame_cnt: got %0d, required 1", frame_cnt_o); end
      total++; if (err_cnt_o !== 16'd0)   begin bad++; $display("FAIL clean err_cnt: got %0d, required 0", err_cnt_o); end
      total++; if (pop_empty != 0) begin bad++; $display("FAIL clean read-while-empty: got %0d, required 0", pop_empty); end
      check_stream("clean");
   endtask

   task automatic test_garbage_prefix();
      do_reset();
      repeat (3) push_word(32'h1234_5678);
      push_clean_frame();
      exp_clean_frame();
      drain("garbage", 0);
      total++; if (err_cnt_o !== 16'd3)   begin bad++; $display("FAIL garbage err_cnt: got %0d, required 3", err_cnt_o); end
      total++; if (frame_cnt_o !== 16'd1) begin bad++; $display("FAIL garbage frame_cnt: got %0d, required 1", frame_cnt_o); end
      check_stream("garbage");
   endtask

   task automatic test_missing_footer();
      do_reset();
      push_word(HDR);
      for (int i = 0; i < NW; i++) push_word(32'(i));
      push_clean_frame();
      exp_word(HDR);
      for (int i = 0; i < NW; i++) exp_word(32'(i));
      exp_clean_frame();
      drain("resync", 0);
      total++; if (err_cnt_o !== 16'd1)   begin bad++; $display("FAIL resync err_cnt: got %0d, required 1", err_cnt_o); end
      total++; if (frame_cnt_o !== 16'd1) begin bad++; $display("FAIL resync frame_cnt: got %0d, required 1", frame_cnt_o); end
      total++;
      if (got_q.size() != 1028 + FRAME_BYTES) begin
         bad++;
         $display("FAIL resync length: got %0d, required %0d", got_q.size(), 1028 + FRAME_BYTES);
      end
      check_stream("resync");
   endtask

   task automatic test_backpressure();
      do_reset();
      push_clean_frame();
      exp_clean_frame();
      drain("backpressure", 1);
      total++; if (stall_cycles < 10) begin bad++; $display("FAIL bp stall cycles: got %0d, required >=10", stall_cycles); end
      total++; if (stall_viol != 0)   begin bad++; $display("FAIL bp byte held: got %0d changes, required 0", stall_viol); end
      total++; if (rd_viol != 0)      begin bad++; $display("FAIL bp read in send: got %0d, required 0", rd_viol); end
      total++; if (frame_cnt_o !== 16'd1) begin bad++; $display("FAIL bp frame_cnt: got %0d, required 1", frame_cnt_o); end
      check_stream("backpressure");
   endtask

   task automatic test_async_reset();
      int cyc = 0;
      do_reset();
      push_clean_frame();
      while (cyc < 5000) begin
         @(posedge clk_i);
         #1;
         cyc++;
         byte_ready_i = 1'b1;
         if (got_q.size() >= 408 && byte_valid_o) break;
      end
      total++;
      if (cyc >= 5000) begin bad++; $display("FAIL arst reach word 100: got %0d bytes, required 408", got_q.size()); end
      #2;
      rst_i = 1'b1;
      #1;
      total++; if (byte_valid_o !== 1'b0) begin bad++; $display("FAIL arst valid drop: got %b, required 0", byte_valid_o); end
      total++; if (busy_o !== 1'b0)       begin bad++; $display("FAIL arst busy: got %b, required 0", busy_o); end
      total++; if (frame_cnt_o !== 16'd0 || err_cnt_o !== 16'd0) begin
         bad++;
         $display("FAIL arst counters: got %0d/%0d, required 0/0", frame_cnt_o, err_cnt_o);
      end
      fifo_q.delete();
      fifo_empty_i = 1'b1;
      @(negedge clk_i);
      got_q.delete();
      exp_q.delete();
      rst_i = 1'b0;
      @(negedge clk_i);
      push_clean_frame();
      exp_clean_frame();
      drain("arst", 0);
      total++; if (frame_cnt_o !== 16'd1) begin bad++; $display("FAIL arst frame_cnt: got %0d, required 1", frame_cnt_o); end
      total++; if (err_cnt_o !== 16'd0)   begin bad++; $display("FAIL arst err_cnt: got %0d, required 0", err_cnt_o); end
      check_stream("arst");
   endtask

   initial begin
      test_reset();
      test_latency();
      test_clean_frame();
      test_garbage_prefix();
      test_missing_footer();
      test_backpressure();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
